vidc_reg_snoop: RTL
===================

Name: vidc_reg_snoop

Overview:
- Snoops host writes to the VIDC register bus and holds a shadow copy of every VIDC1 register the output path needs: palette, cursor palette, border, H/V timing, cursor position and control.
- Sits directly upstream of the video block and drives its palette, cursor, special-register and tregs status/ack inputs.
- Synchronises the asynchronous VIDC write strobe into clk, decodes the address field and commits data.
- Flags changes to timing registers so the MCU can reprogram the output timing.

Parameters:
- SYNC_STAGES, 2, flops in the strobe/data synchroniser chain (minimum 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- vidc_d  in  32  VIDC data bus, asynchronous. [31:26] is the register address; the remaining bits are data.
- vidc_nvidw  in  1  VIDC write strobe, asynchronous, active-low.
- vidc_tregs_ack  in  1  level ack from the MCU, via the video block.
- vidc_palette  out  192  16 logical colours x 12 bits; entry n is at [12n+11:12n].
- vidc_cursor_palette  out  36  cursor colours 1..3; colour k is at [12(k-1)+11:12(k-1)].
- vidc_border  out  12  border colour.
- vidc_htregs  out  60  HCR, HSWR, HBSR, HDSR, HDER, HBER; each 10 bits; HCR in [9:0].
- vidc_vtregs  out  60  VCR, VSWR, VBSR, VDSR, VDER, VBER; same packing as vidc_htregs.
- vidc_ctrl  out  8  control register.
- v_cursor_x  out  11  HCSR, raw value.
- v_cursor_y  out  10  VCSR.
- v_cursor_yend  out  10  VCER.
- vidc_special  out  24  ArcDVI extension register A.
- vidc_special_data  out  24  ArcDVI extension register B.
- vidc_special_written  out  1  one-cycle pulse when vidc_special_data is committed.
- vidc_tregs_status  out  1  sticky flag: timing or control registers changed.

Behaviour:
- Reset (reset=0) asynchronously clears every register and output to 0, including the synchroniser chain.
- Synchroniser:
  - vidc_nvidw and vidc_d each pass through SYNC_STAGES flops.
  - The data chain is one stage deeper than the strobe chain, so the committed data is the value sampled before the strobe edge was seen.
- Commit:
  - A write commits on a detected 0->1 transition of the synchronised strobe (end of write).
  - Commit happens SYNC_STAGES+1 clk cycles after the raw rising edge.
  - At most one commit per strobe pulse.
  - A strobe low for fewer than 2 clk cycles may be missed. This is permitted because clk is at least 4x the VIDC write rate.
- Decode, with A = d[31:26]:
  - 0x00-0x0F: palette[A] <= d[11:0].
  - 0x10: border <= d[11:0].
  - 0x11-0x13: cursor colour A-0x10 <= d[11:0].
  - 0x20-0x25: htregs[A-0x20] <= d[23:14].
  - 0x26: v_cursor_x <= d[23:13].
  - 0x28-0x2D: vtregs[A-0x28] <= d[23:14].
  - 0x2E: v_cursor_y <= d[23:14].
  - 0x2F: v_cursor_yend <= d[23:14].
  - 0x38: ctrl <= d[7:0].
  - 0x3E: vidc_special <= d[23:0].
  - 0x3F: vidc_special_data <= d[23:0], and vidc_special_written pulses for exactly 1 cycle, coincident with the output update.
  - All other addresses (sound, stereo, 0x27 HIR) are ignored with no side effect.
- tregs status, two states (CLEAN, CHANGED):
  - CLEAN->CHANGED on a commit to htregs, vtregs or ctrl whose new value differs from the stored value. Equal rewrites do not set the flag.
  - CHANGED->CLEAN on a rising edge of vidc_tregs_ack, detected internally by registering the previous ack level.
  - If a set and a clear occur in the same cycle, set wins and the state stays CHANGED.
  - A held-high ack clears only once; a later change sets the flag again while ack is still high.
- Outputs are registered and updated in the commit cycle. There is no partial update of packed buses.
- Reset asserted mid-write aborts it; the strobe pulse is not committed after reset release unless a fresh 0->1 edge is detected.

Test Plan:
- Palette: write d=0x0800_0ABC (A=2), pulse low 4 cycles -> vidc_palette[35:24]=0xABC SYNC_STAGES+1 cycles after the strobe rise; other entries unchanged.
- Timing change: write HCR (A=0x20) with d[23:14]=0x0C3 -> vidc_htregs[9:0]=0x0C3, vidc_tregs_status=1. Raise ack -> status 0 next cycle. Rewrite 0x0C3 -> status stays 0.
- Set/clear collision: commit a changed VCR in the same cycle as the ack rising edge -> status remains 1. Ack then held high -> no further clear until ack falls and rises again.
- Cursor: A=0x26 with d[23:13]=0x1A4 -> v_cursor_x=0x1A4. A=0x2E/0x2F with 0x020/0x040 -> v_cursor_y=0x020, v_cursor_yend=0x040. Status not set.
- Special: A=0x3E d=0x123456, then A=0x3F d=0xABCDEF -> vidc_special=0x123456, vidc_special_data=0xABCDEF, vidc_special_written high exactly 1 cycle, only on the second write.
- Reset: assert reset while the strobe is low, release, then let the strobe rise -> all outputs 0 and no commit; the next full write commits normally.

Source files
------------

// File: rtl/vidc_reg_snoop.sv
// Shadows VIDC1 register writes for the video output path.
// It synchronises the async write strobe and data, decodes the address, and flags timing changes.
module vidc_reg_snoop #(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  vidc_d,
  input  logic         vidc_nvidw,
  input  logic         vidc_tregs_ack,
  output logic [191:0] vidc_palette,
  output logic [35:0]  vidc_cursor_palette,
  output logic [11:0]  vidc_border,
  output logic [59:0]  vidc_htregs,
  output logic [59:0]  vidc_vtregs,
  output logic [7:0]   vidc_ctrl,
  output logic [10:0]  v_cursor_x,
  output logic [9:0]   v_cursor_y,
  output logic [9:0]   v_cursor_yend,
  output logic [23:0]  vidc_special,
  output logic [23:0]  vidc_special_data,
  output logic         vidc_special_written,
  output logic         vidc_tregs_status
);

  typedef enum logic {CLEAN, CHANGED} tstate_t;

  // The extra strobe flop gives the edge detector its previous value.
  // The data chain is one stage deeper, so it lags the strobe by one sample.
  logic [SYNC_STAGES:0]       nvidw_sync;
  logic [SYNC_STAGES:0][31:0] d_sync;
  logic                       armed;
  logic                       ack_prev;
  tstate_t                    state, state_nxt;

  logic        strobe_rise, strobe_fall, commit, ack_rise, tregs_chg;
  logic [5:0]  a;
  logic [31:0] wd;
  logic        unused_bits;

  assign strobe_rise = nvidw_sync[SYNC_STAGES-1] & ~nvidw_sync[SYNC_STAGES];
  assign strobe_fall = ~nvidw_sync[SYNC_STAGES-1] & nvidw_sync[SYNC_STAGES];
  // A commit needs a falling edge seen since reset. This drops a write that reset
  // interrupted, and it also drops the 0->1 edge the chain shows as it leaves reset.
  assign commit      = strobe_rise & armed;
  assign wd          = d_sync[SYNC_STAGES];
  assign a           = wd[31:26];
  assign unused_bits = ^wd[25:24];
  assign ack_rise    = vidc_tregs_ack & ~ack_prev;
  assign vidc_tregs_status = (state == CHANGED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nvidw_sync <= '0;
      d_sync     <= '0;
      armed      <= 1'b0;
      ack_prev   <= 1'b0;
    end else begin
      nvidw_sync <= {nvidw_sync[SYNC_STAGES-1:0], vidc_nvidw};
      d_sync     <= {d_sync[SYNC_STAGES-1:0], vidc_d};
      ack_prev   <= vidc_tregs_ack;
      if (strobe_fall)      armed <= 1'b1;
      else if (strobe_rise) armed <= 1'b0;
    end
  end

  always_comb begin
    tregs_chg = 1'b0;
    if (commit) begin
      case (a) inside
        [6'h20:6'h25]: tregs_chg = (vidc_htregs[10*a[2:0] +: 10] != wd[23:14]);
        [6'h28:6'h2D]: tregs_chg = (vidc_vtregs[10*a[2:0] +: 10] != wd[23:14]);
        6'h38:         tregs_chg = (vidc_ctrl != wd[7:0]);
        default:       tregs_chg = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vidc_palette         <= '0;
      vidc_cursor_palette  <= '0;
      vidc_border          <= '0;
      vidc_htregs          <= '0;
      vidc_vtregs          <= '0;
      vidc_ctrl            <= '0;
      v_cursor_x           <= '0;
      v_cursor_y           <= '0;
      v_cursor_yend        <= '0;
      vidc_special         <= '0;
      vidc_special_data    <= '0;
      vidc_special_written <= 1'b0;
    end else begin
      vidc_special_written <= 1'b0;
      if (commit) begin
        case (a) inside
          [6'h00:6'h0F]: vidc_palette[12*a[3:0] +: 12] <= wd[11:0];
          6'h10:         vidc_border <= wd[11:0];
          [6'h11:6'h13]: vidc_cursor_palette[12*(a[1:0]-2'd1) +: 12] <= wd[11:0];
          [6'h20:6'h25]: vidc_htregs[10*a[2:0] +: 10] <= wd[23:14];
          6'h26:         v_cursor_x <= wd[23:13];
          [6'h28:6'h2D]: vidc_vtregs[10*a[2:0] +: 10] <= wd[23:14];
          6'h2E:         v_cursor_y <= wd[23:14];
          6'h2F:         v_cursor_yend <= wd[23:14];
          6'h38:         vidc_ctrl <= wd[7:0];
          6'h3E:         vidc_special <= wd[23:0];
          6'h3F: begin
            vidc_special_data    <= wd[23:0];
            vidc_special_written <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= CLEAN;
    else        state <= state_nxt;
  end

  // If a set and a clear land in the same cycle, the set takes priority.
  always_comb begin
    state_nxt = state;
    if (tregs_chg)     state_nxt = CHANGED;
    else if (ack_rise) state_nxt = CLEAN;
  end

endmodule
